// File: rtl/phys_reg_free_list_pkg.sv
// Shared types, sizing and helpers for the physical-register free list.
package phys_reg_free_list_pkg;

  localparam int unsigned NUM_PHYREG  = 128;
  localparam int unsigned NUM_ARCHREG = 32;
  localparam int unsigned DEPTH       = NUM_PHYREG - NUM_ARCHREG;

  localparam int unsigned PREG_W = $clog2(NUM_PHYREG);
  localparam int unsigned AREG_W = $clog2(NUM_ARCHREG);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  typedef logic [PREG_W-1:0] PhyRegisterId_T;
  typedef logic [AREG_W-1:0] ArchRegisterId_T;
  typedef logic [PTR_W-1:0]  FreeListPtr_T;
  typedef logic [CNT_W-1:0]  FreeCount_T;

  // DEPTH is not a power of two, so the wrap must be explicit.
  function automatic FreeListPtr_T ptrInc(input FreeListPtr_T ptr);
    return (ptr == FreeListPtr_T'(DEPTH - 1)) ? '0 : ptr + FreeListPtr_T'(1);
  endfunction

  // Commit payload travelling from the ROB, carried like RobToRru.
  typedef struct packed {
    logic           commitValid;
    PhyRegisterId_T prevPhyReg;
  } RobToFreeList;

  function automatic RobToFreeList robToFreeListEncap(input logic commitValid,
                                                      input PhyRegisterId_T prevPhyReg);
    RobToFreeList pkt;
    pkt.commitValid = commitValid;
    pkt.prevPhyReg  = prevPhyReg;
    return pkt;
  endfunction

  function automatic void robToFreeListDecap(input RobToFreeList pkt,
                                             output logic commitValid,
                                             output PhyRegisterId_T prevPhyReg);
    commitValid = pkt.commitValid;
    prevPhyReg  = pkt.prevPhyReg;
  endfunction

endpackage

// File: rtl/phys_reg_free_list_ram.sv
// Free-list storage: DEPTH physical-register ids, async read at the spec head,
// one write at the tail, reset to the non-architectural pregs in order.
module phys_reg_free_list_ram
  import phys_reg_free_list_pkg::*;
(
  input  logic                SIG_CLK,
  input  logic                SIG_RST,
  input  logic [PTR_W-1:0]    rdAddr,
  output logic [PREG_W-1:0]   rdData,
  input  logic                wrEn,
  input  logic [PTR_W-1:0]    wrAddr,
  input  logic [PREG_W-1:0]   wrData
);

  PhyRegisterId_T mem [DEPTH];

  // Entry storage; reset fills entry i with preg NUM_ARCHREG+i.
  always_ff @(posedge SIG_CLK or posedge SIG_RST) begin
    if (SIG_RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= PhyRegisterId_T'(NUM_ARCHREG + i);
      end
    end else if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  // Combinational read so the grant can be issued in the request cycle.
  always_comb begin
    rdData = mem[rdAddr];
  end

endmodule

// File: rtl/phys_reg_free_list.sv
// Physical register free list: speculative allocation for rename, reclaim on
// ROB commit, single-cycle rollback of speculative allocations on flush.
module phys_reg_free_list
  import phys_reg_free_list_pkg::*;
(
  input  logic                SIG_CLK,
  input  logic                SIG_RST,
  input  logic                alloc_req,
  output logic                alloc_gnt,
  output logic [PREG_W-1:0]   alloc_preg,
  input  logic                commit_valid,
  input  logic [PREG_W-1:0]   commit_prev_preg,
  input  logic                flush,
  output logic [CNT_W-1:0]    free_count,
  output logic                empty,
  output logic                proto_err
);

  FreeListPtr_T   specHead;
  FreeListPtr_T   commitHead;
  FreeListPtr_T   tail;
  FreeCount_T     freeCount;
  logic           emptyQ;
  logic           protoErr;

  FreeListPtr_T   specHeadNext;
  FreeListPtr_T   commitHeadNext;
  FreeListPtr_T   tailNext;
  FreeCount_T     freeCountNext;
  logic           emptyNext;
  logic           protoErrNext;

  RobToFreeList   commitPkt;
  logic           commitValid;
  PhyRegisterId_T prevPhyReg;
  PhyRegisterId_T ramRdData;
  logic           hasFree;
  logic           noOutstanding;

  // Unpack the commit interface into its payload fields.
  always_comb begin
    commitValid = 1'b0;
    prevPhyReg  = '0;
    commitPkt   = robToFreeListEncap(commit_valid, commit_prev_preg);
    robToFreeListDecap(commitPkt, commitValid, prevPhyReg);
  end

  phys_reg_free_list_ram u_ram (
    .SIG_CLK (SIG_CLK),
    .SIG_RST (SIG_RST),
    .rdAddr  (specHead),
    .rdData  (ramRdData),
    .wrEn    (commitValid),
    .wrAddr  (tail),
    .wrData  (prevPhyReg)
  );

  // Zero-latency grant; suppressed during flush, reset, or when the list is empty.
  always_comb begin
    hasFree    = (freeCount != '0);
    alloc_gnt  = alloc_req & ~flush & hasFree & ~SIG_RST;
    alloc_preg = hasFree ? ramRdData : '0;
  end

  // Pointer, count and error next-state; commit is applied before any flush rollback.
  always_comb begin
    commitHeadNext = commitHead;
    tailNext       = tail;
    specHeadNext   = specHead;
    freeCountNext  = freeCount;
    protoErrNext   = protoErr;
    noOutstanding  = (commitHead == specHead) && (freeCount == FreeCount_T'(DEPTH));

    if (commitValid) begin
      commitHeadNext = ptrInc(commitHead);
      tailNext       = ptrInc(tail);
      if (noOutstanding || (prevPhyReg == '0)) begin
        protoErrNext = 1'b1;
      end
    end

    if (flush) begin
      specHeadNext  = commitHeadNext;
      freeCountNext = FreeCount_T'(DEPTH);
    end else begin
      if (alloc_gnt) begin
        specHeadNext = ptrInc(specHead);
      end
      case ({commitValid, alloc_gnt})
        2'b10:   freeCountNext = freeCount + FreeCount_T'(1);
        2'b01:   freeCountNext = freeCount - FreeCount_T'(1);
        default: freeCountNext = freeCount;
      endcase
    end

    emptyNext = (freeCountNext == '0);
  end

  // State registers.
  always_ff @(posedge SIG_CLK or posedge SIG_RST) begin
    if (SIG_RST) begin
      specHead   <= '0;
      commitHead <= '0;
      tail       <= '0;
      freeCount  <= FreeCount_T'(DEPTH);
      emptyQ     <= 1'b0;
      protoErr   <= 1'b0;
    end else begin
      specHead   <= specHeadNext;
      commitHead <= commitHeadNext;
      tail       <= tailNext;
      freeCount  <= freeCountNext;
      emptyQ     <= emptyNext;
      protoErr   <= protoErrNext;
    end
  end

  assign free_count = freeCount;
  assign empty      = emptyQ;
  assign proto_err  = protoErr;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Bench for phys_reg_free_list: directed scenarios plus random traffic against
// a queue model of the free list (committed window + outstanding-allocation count).
module tb_phys_reg_free_list;

  localparam int DEPTH = 96;
  localparam int NARCH = 32;

  logic       SIG_CLK;
  logic       SIG_RST;
  logic       alloc_req;
  logic       alloc_gnt;
  logic [6:0] alloc_preg;
  logic       commit_valid;
  logic [6:0] commit_prev_preg;
  logic       flush;
  logic [6:0] free_count;
  logic       empty;
  logic       proto_err;

  phys_reg_free_list dut (
    .SIG_CLK          (SIG_CLK),
    .SIG_RST          (SIG_RST),
    .alloc_req        (alloc_req),
    .alloc_gnt        (alloc_gnt),
    .alloc_preg       (alloc_preg),
    .commit_valid     (commit_valid),
    .commit_prev_preg (commit_prev_preg),
    .flush            (flush),
    .free_count       (free_count),
    .empty            (empty),
    .proto_err        (proto_err)
  );

  initial SIG_CLK = 1'b0;
  always #5 SIG_CLK = ~SIG_CLK;

  int total = 0;
  int bad   = 0;

  // Model: q holds the DEPTH entries from commit head onward; the first n are
  // speculatively allocated, the rest are free.
  int q[$];
  int n;
  bit perr;
  logic [6:0] gotPreg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    q.delete();
    for (int i = 0; i < DEPTH; i++) q.push_back(NARCH + i);
    n = 0;
    perr = 0;
  endtask

  // One clock of stimulus: check combinational grant, advance model, check registered outputs.
  task automatic step(input bit req, input bit cv, input int prev, input bit fl);
    bit expG;
    int expP;
    int nOld;
    @(negedge SIG_CLK);
    alloc_req = req;
    commit_valid = cv;
    commit_prev_preg = 7'(prev);
    flush = fl;
    #1;
    expG = req && !fl && (n < DEPTH);
    expP = (n < DEPTH) ? q[n] : 0;
    chk("alloc_gnt", 32'(alloc_gnt), 32'(expG));
    chk("alloc_preg", 32'(alloc_preg), 32'(expP));
    gotPreg = alloc_preg;
    @(posedge SIG_CLK);
    nOld = n;
    if (expG) n++;
    if (cv) begin
      if (nOld == 0 || prev == 0) perr = 1;
      q.push_back(prev);
      void'(q.pop_front());
      n--;
    end
    if (fl) n = 0;
    #1;
    chk("free_count", 32'(free_count), 32'(DEPTH - n));
    chk("empty", 32'(empty), 32'(n == DEPTH));
    chk("proto_err", 32'(proto_err), 32'(perr));
  endtask

  task automatic doReset();
    @(negedge SIG_CLK);
    SIG_RST = 1'b1;
    alloc_req = 1'b1;
    commit_valid = 1'b0;
    flush = 1'b0;
    #1;
    chk("rst_gnt", 32'(alloc_gnt), 32'd0);
    @(posedge SIG_CLK);
    #1;
    chk("rst_count", 32'(free_count), 32'(DEPTH));
    chk("rst_empty", 32'(empty), 32'd0);
    chk("rst_perr", 32'(proto_err), 32'd0);
    modelReset();
    @(negedge SIG_CLK);
    SIG_RST = 1'b0;
    alloc_req = 1'b0;
  endtask

  initial begin
    SIG_RST = 1'b0;
    alloc_req = 1'b0;
    commit_valid = 1'b0;
    commit_prev_preg = '0;
    flush = 1'b0;
    modelReset();

    // Drain the whole list back to back.
    doReset();
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 0, 0);
      chk("drain_preg", 32'(gotPreg), 32'(NARCH + i));
    end
    chk("drain_count", 32'(free_count), 32'd0);
    chk("drain_empty", 32'(empty), 32'd1);

    // Stall on empty, then a commit makes exactly that preg available.
    repeat (5) step(1, 0, 0, 0);
    step(0, 1, 40, 0);
    step(1, 0, 0, 0);
    chk("refill_preg", 32'(gotPreg), 32'd40);
    step(0, 0, 0, 1);

    // Allocate 10, commit 3, flush: rollback to committed head.
    doReset();
    repeat (10) step(1, 0, 0, 0);
    step(0, 1, 5, 0);
    step(0, 1, 6, 0);
    step(0, 1, 7, 0);
    step(0, 0, 0, 1);
    chk("flush_count", 32'(free_count), 32'(DEPTH));
    step(1, 0, 0, 0);
    chk("flush_preg", 32'(gotPreg), 32'd35);

    // Alloc+commit at count 1, freed preg only seen after wrap.
    doReset();
    repeat (DEPTH - 1) step(1, 0, 0, 0);
    step(1, 1, 9, 0);
    chk("same_cyc_preg", 32'(gotPreg), 32'd127);
    chk("same_cyc_count", 32'(free_count), 32'd1);
    step(1, 0, 0, 0);
    chk("wrap_preg", 32'(gotPreg), 32'd9);

    // Flush together with commit and alloc request.
    step(1, 1, 20, 1);
    chk("fl_cm_count", 32'(free_count), 32'(DEPTH));
    step(1, 0, 0, 0);
    chk("fl_cm_preg", 32'(gotPreg), 32'd34);

    // Random legal traffic against the model.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      bit r;
      bit c;
      bit f;
      r = ($urandom % 4) != 0;
      c = (n > 0) && (($urandom % 3) == 0);
      f = ($urandom % 60) == 0;
      step(r, c, int'($urandom_range(1, 127)), f);
    end

    // Commit with nothing outstanding sets a sticky error.
    step(0, 0, 0, 1);
    step(0, 1, 50, 1);
    chk("perr_noout", 32'(proto_err), 32'd1);
    repeat (3) step(0, 0, 0, 0);
    chk("perr_sticky", 32'(proto_err), 32'd1);
    doReset();

    // Returning preg 0 is a protocol error.
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("perr_zero", 32'(proto_err), 32'd1);
    doReset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
